// File: rtl/rom_seq_pkg.sv
// Shared types for the ROM read sequencer.
package rom_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_LAT   = 2'd2,
    S_VALID = 2'd3
  } state_t;

endpackage

// File: rtl/rom_sequencer.sv
// Walks a synchronous ROM between two addresses, absorbs its read latency and
// hands each word downstream on a valid/ready stream.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_ADDR  | ADDR stable, ROM samples it this edge
// S_LAT   | ROM output valid, captured into data_out
// S_VALID | word offered downstream until handshake
module rom_sequencer
  import rom_seq_pkg::*;
#(
  parameter int BITS_DATA = 8,
  parameter int BITS_ADDR = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BITS_ADDR-1:0] first_addr,
  input  logic [BITS_ADDR-1:0] last_addr,
  input  logic                 loop,
  input  logic                 abort,
  output logic [BITS_ADDR-1:0] ADDR,
  input  logic [BITS_DATA-1:0] rom_data,
  output logic [BITS_DATA-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 done,
  output logic [BITS_ADDR:0]   word_cnt
);

  localparam logic [BITS_ADDR-1:0] ADDR_ONE = 1;
  localparam logic [BITS_ADDR:0]   CNT_ONE  = 1;
  localparam logic [BITS_ADDR:0]   CNT_MAX  = '1;

  state_t                 state, state_nxt;
  logic [BITS_ADDR-1:0]   first_q, last_q;
  logic                   loop_q;
  logic                   latch;
  logic [BITS_ADDR-1:0]   addr_nxt;
  logic [BITS_DATA-1:0]   dout_nxt;
  logic                   valid_nxt;
  logic                   done_nxt;
  logic [BITS_ADDR:0]     cnt_nxt;
  logic                   hs;

  assign busy = (state != S_IDLE);
  assign hs   = data_valid & data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      first_q    <= '0;
      last_q     <= '0;
      loop_q     <= 1'b0;
      ADDR       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      done       <= 1'b0;
      word_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      ADDR       <= addr_nxt;
      data_out   <= dout_nxt;
      data_valid <= valid_nxt;
      done       <= done_nxt;
      word_cnt   <= cnt_nxt;
      if (latch) begin
        first_q <= first_addr;
        last_q  <= last_addr;
        loop_q  <= loop;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = ADDR;
    dout_nxt  = data_out;
    valid_nxt = data_valid;
    done_nxt  = 1'b0;
    cnt_nxt   = word_cnt;
    latch     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          latch     = 1'b1;
          addr_nxt  = first_addr;
          cnt_nxt   = '0;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: state_nxt = S_LAT;
      S_LAT: begin
        dout_nxt  = rom_data;
        valid_nxt = 1'b1;
        state_nxt = S_VALID;
      end
      S_VALID: begin
        if (hs) begin
          if (word_cnt != CNT_MAX) cnt_nxt = word_cnt + CNT_ONE;
          valid_nxt = 1'b0;
          if (ADDR != last_q) begin
            addr_nxt  = ADDR + ADDR_ONE;
            state_nxt = S_ADDR;
          end else if (loop_q) begin
            addr_nxt  = first_q;
            state_nxt = S_ADDR;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort wins over everything except the word count of a same-cycle handshake.
    if (state != S_IDLE && abort) begin
      state_nxt = S_IDLE;
      addr_nxt  = ADDR;
      dout_nxt  = data_out;
      valid_nxt = 1'b0;
      done_nxt  = 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_sequencer.sv
// Self-checking bench for rom_sequencer: directed table, corner sequences and
// randomized runs checked against an address-arithmetic model of the walk.
module tb_rom_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] first_addr, last_addr;
  logic       loop;
  logic       abort;
  logic [2:0] ADDR;
  logic [7:0] rom_data;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       done;
  logic [3:0] word_cnt;

  logic [7:0] mem [8];

  int vectors    = 0;
  int miscompares = 0;

  rom_sequencer #(.BITS_DATA(8), .BITS_ADDR(3)) dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr),
    .last_addr(last_addr), .loop(loop), .abort(abort), .ADDR(ADDR),
    .rom_data(rom_data), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[ADDR];

  typedef struct {
    int first;
    int last;
    int lp;
    int nhs;
    int mode;        // 0 ready=1, 1 random ready, 2 ready low 5 cycles on 2nd word
    int abort_mode;  // 0 none, 1 abort after last handshake, 2 abort with last handshake
    int exp_fw;
    int exp_lw;
    int exp_cnt;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_addr(input int first, input int last, input int k);
    int len;
    len = ((last - first) & 7) + 1;
    return (first + (k % len)) & 7;
  endfunction

  task automatic run(input int first, input int last, input int lp, input int nhs,
                     input int mode, input int abort_mode,
                     output int fw, output int lw, output int fcnt);
    int k, cyc, lowcnt, last_hs_cyc, ea;
    bit prev_hold, first_seen, fin, r;
    logic [7:0] prev_data;
    fw = -1; lw = -1;
    @(negedge clk);
    first_addr = 3'(first); last_addr = 3'(last); loop = lp[0];
    start = 1'b1; data_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; k = 0; lowcnt = 0; last_hs_cyc = 0;
    prev_hold = 0; first_seen = 0; fin = 0; prev_data = '0;
    while (!fin && cyc < 400) begin
      chk("word_cnt", word_cnt, (k > 15) ? 15 : k);
      chk("busy_run", busy, 1);
      if (prev_hold) begin
        chk("hold_valid", data_valid, 1);
        chk("hold_data", data_out, prev_data);
      end
      if (data_valid && !first_seen) begin
        first_seen = 1;
        chk("latency", cyc, 3);
      end
      case (mode)
        0: r = 1;
        1: r = ($urandom_range(0, 1) == 1);
        default: begin
          r = !(k == 1 && lowcnt < 5);
          if (k == 1 && data_valid && lowcnt < 5) lowcnt++;
        end
      endcase
      data_ready = r;
      abort = (abort_mode == 2 && k == nhs - 1 && data_valid && r);
      if (data_valid && r) begin
        ea = exp_addr(first, last, k);
        chk("addr", ADDR, ea);
        chk("data", data_out, 8'hA0 + ea);
        if (k == 0) fw = data_out;
        lw = data_out;
        if (mode == 0 && k > 0) chk("throughput", cyc - last_hs_cyc, 3);
        last_hs_cyc = cyc;
        k++;
        prev_hold = 0;
        if (k == nhs) fin = 1;
      end else begin
        prev_hold = data_valid;
        prev_data = data_out;
      end
      @(negedge clk);
      cyc++;
    end
    data_ready = 1'b0;
    abort = 1'b0;
    if (!fin) chk("words_before_timeout", k, nhs);
    if (abort_mode == 1) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    chk("done_end", done, 1);
    chk("busy_end", busy, 0);
    chk("valid_end", data_valid, 0);
    fcnt = word_cnt;
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int fw, lw, fcnt, f, l, lp, nhs, am, n;
    for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
    rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0; loop = 1'b0;
    abort = 1'b0; data_ready = 1'b0;
    tbl[0] = '{2, 5, 0, 4,  0, 0, 'hA2, 'hA5, 4};
    tbl[1] = '{6, 1, 0, 4,  0, 0, 'hA6, 'hA1, 4};
    tbl[2] = '{2, 5, 0, 4,  2, 0, 'hA2, 'hA5, 4};
    tbl[3] = '{3, 4, 1, 6,  0, 1, 'hA3, 'hA4, 6};
    tbl[4] = '{4, 4, 0, 1,  0, 0, 'hA4, 'hA4, 1};
    tbl[5] = '{0, 7, 0, 8,  1, 0, 'hA0, 'hA7, 8};
    tbl[6] = '{5, 4, 0, 8,  1, 2, 'hA5, 'hA4, 8};
    tbl[7] = '{1, 2, 1, 18, 0, 2, 'hA1, 'hA2, 15};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_addr", ADDR, 0);
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", word_cnt, 0);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_done", done, 0);

    for (int i = 0; i < 8; i++) begin
      run(tbl[i].first, tbl[i].last, tbl[i].lp, tbl[i].nhs, tbl[i].mode,
          tbl[i].abort_mode, fw, lw, fcnt);
      chk($sformatf("tbl%0d_first_word", i), fw, tbl[i].exp_fw);
      chk($sformatf("tbl%0d_last_word", i), lw, tbl[i].exp_lw);
      chk($sformatf("tbl%0d_cnt", i), fcnt, tbl[i].exp_cnt);
    end

    // start while busy is ignored, then reset mid-run in VALID
    first_addr = 3'd1; last_addr = 3'd3; loop = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!data_valid && n < 10) begin @(negedge clk); n++; end
    chk("busy_start_valid", data_valid, 1);
    chk("busy_start_w0", data_out, 8'hA1);
    first_addr = 3'd5; last_addr = 3'd5; loop = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_data", data_out, 8'hA1);
    chk("ignored_start_addr", ADDR, 1);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    n = 0;
    while (!data_valid && n < 10) begin @(negedge clk); n++; end
    chk("ignored_start_w1", data_out, 8'hA2);
    chk("ignored_start_a1", ADDR, 2);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    chk("midrst_addr", ADDR, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_valid", data_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cnt", word_cnt, 0);
    @(negedge clk);
    chk("midrst_done_later", done, 0);
    chk("midrst_busy_later", busy, 0);

    for (int i = 0; i < 20; i++) begin
      f  = $urandom_range(0, 7);
      l  = $urandom_range(0, 7);
      lp = $urandom_range(0, 1);
      if (lp == 1) begin
        nhs = $urandom_range(1, 20);
        am  = $urandom_range(1, 2);
      end else begin
        nhs = ((l - f) & 7) + 1;
        am  = 2 * $urandom_range(0, 1);
      end
      run(f, l, lp, nhs, 1, am, fw, lw, fcnt);
      chk("rnd_first_word", fw, 8'hA0 + f);
      chk("rnd_last_word", lw, 8'hA0 + exp_addr(f, l, nhs - 1));
      chk("rnd_cnt", fcnt, (nhs > 15) ? 15 : nhs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
